// File: rtl/out2int_pkg.sv
// Shared portal-to-pipe constants: message layout and default requester count.
package out2int_pkg;

  localparam int unsigned LenW     = 16;
  localparam int unsigned MethodW  = 16;
  localparam int unsigned TagW     = 16;
  localparam int unsigned HdrW     = 16;
  localparam int unsigned PayloadW = 128;
  localparam int unsigned MsgW     = HdrW + PayloadW;
  localparam int unsigned DefNport = 4;
  localparam int unsigned CountW   = 16;

  typedef struct packed {
    logic [LenW-1:0]    len;
    logic [MethodW-1:0] method;
    logic [TagW-1:0]    tag;
  } portal_hdr_t;

endpackage

// File: rtl/m2p_fifo2.sv
// Two-entry message FIFO; accepts a push when full if a pop happens on the same edge.
module m2p_fifo2
  import out2int_pkg::*;
#(
  parameter int unsigned MSGW = MsgW
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            i_enq_ena,
  input  logic [MSGW-1:0] i_enq_data,
  output logic            o_enq_rdy,
  input  logic            i_deq_ena,
  output logic            o_deq_rdy,
  output logic [MSGW-1:0] o_deq_data,
  output logic [1:0]      o_count
);

  logic [MSGW-1:0] r_mem [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;
  logic            w_enq;
  logic            w_deq;

  assign w_deq      = i_deq_ena && (r_count != 2'd0);
  assign o_enq_rdy  = (r_count != 2'd2) || w_deq;
  assign w_enq      = i_enq_ena && o_enq_rdy;
  assign o_deq_rdy  = (r_count != 2'd0);
  assign o_deq_data = r_mem[r_rptr];
  assign o_count    = r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  always_ff @(posedge CLK) begin
    if (w_enq) r_mem[r_wptr] <= i_enq_data;
  end

endmodule

// File: rtl/m2p_pipe_arbiter.sv
// Round-robin merge of NPORT single-slot requesters into one pipe via a 2-entry FIFO.
module m2p_pipe_arbiter
  import out2int_pkg::*;
#(
  parameter int unsigned NPORT = DefNport,
  parameter int unsigned MSGW  = MsgW
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NPORT-1:0]      in_enq_ena_i,
  input  logic [NPORT*MSGW-1:0] in_enq_v_i,
  output logic [NPORT-1:0]      in_enq_rdy_o,
  output logic                  pipe_enq_ena_o,
  output logic [MSGW-1:0]       pipe_enq_v_o,
  input  logic                  pipe_enq_rdy_i,
  output logic [CountW-1:0]     stat_count_o
);

  localparam int unsigned PtrW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0]  r_hold_v;
  logic [MSGW-1:0]   r_hold_d [NPORT];
  logic [PtrW-1:0]   r_rr;
  logic [CountW-1:0] r_count;

  logic              w_found;
  logic [PtrW-1:0]   w_win;
  logic [PtrW-1:0]   w_idx;
  logic [PtrW-1:0]   w_rr_next;
  logic              w_move;
  logic              w_pop;
  logic              w_fifo_enq_rdy;
  logic              w_fifo_deq_rdy;
  logic [MSGW-1:0]   w_fifo_head;
  logic [1:0]        w_fifo_count;

  // First set hold slot at or after r_rr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      w_idx = PtrW'((32'(r_rr) + k) % NPORT);
      if (!w_found && r_hold_v[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_move    = w_found && w_fifo_enq_rdy;
  assign w_pop     = pipe_enq_ena_o && pipe_enq_rdy_i;
  assign w_rr_next = (w_win == PtrW'(NPORT - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hold_v <= '0;
      r_rr     <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (w_move && (w_win == PtrW'(i))) begin
          r_hold_v[i] <= 1'b0;
        end else if (in_enq_ena_i[i] && !r_hold_v[i]) begin
          r_hold_v[i] <= 1'b1;
        end
      end
      if (w_move) r_rr <= w_rr_next;
      if (w_pop) r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NPORT; i++) begin
      if (in_enq_ena_i[i] && !r_hold_v[i]) r_hold_d[i] <= in_enq_v_i[i*MSGW +: MSGW];
    end
  end

  m2p_fifo2 #(
    .MSGW (MSGW)
  ) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_enq_ena  (w_found),
    .i_enq_data (r_hold_d[w_win]),
    .o_enq_rdy  (w_fifo_enq_rdy),
    .i_deq_ena  (pipe_enq_rdy_i),
    .o_deq_rdy  (w_fifo_deq_rdy),
    .o_deq_data (w_fifo_head),
    .o_count    (w_fifo_count)
  );

  assign in_enq_rdy_o   = ~r_hold_v;
  assign pipe_enq_ena_o = w_fifo_deq_rdy;
  assign pipe_enq_v_o   = w_fifo_head;
  assign stat_count_o   = r_count;

  // FIFO occupancy and its valid flag must always agree.
  assert property (@(posedge CLK) disable iff (!nRST)
                   (w_fifo_count <= 2'd2) && (w_fifo_deq_rdy == (w_fifo_count != 2'd0)));

endmodule

// File: tb/tb_m2p_pipe_arbiter.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
module tb_m2p_pipe_arbiter;

  localparam int unsigned NPORT = 4;
  localparam int unsigned MSGW  = 144;

  logic                  CLK  = 1'b0;
  logic                  nRST = 1'b1;
  logic [NPORT-1:0]      ena  = '0;
  logic [NPORT*MSGW-1:0] vin  = '0;
  logic                  prdy = 1'b0;
  logic [NPORT-1:0]      rdy;
  logic                  pena;
  logic [MSGW-1:0]       pv;
  logic [15:0]           cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  m2p_pipe_arbiter #(
    .NPORT (NPORT),
    .MSGW  (MSGW)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .in_enq_ena_i   (ena),
    .in_enq_v_i     (vin),
    .in_enq_rdy_o   (rdy),
    .pipe_enq_ena_o (pena),
    .pipe_enq_v_o   (pv),
    .pipe_enq_rdy_i (prdy),
    .stat_count_o   (cnt)
  );

  // Reference model state
  logic            m_hv [NPORT];
  logic [MSGW-1:0] m_hd [NPORT];
  logic [MSGW-1:0] m_fifo [$];
  int              m_rr;
  logic [15:0]     m_cnt;
  logic            m_acc [NPORT];
  logic            m_pop;
  int              m_win;
  logic [NPORT-1:0] m_erdy;

  logic [MSGW-1:0] dlog [$];
  int              dcyc [$];
  int              cyc = 0;
  int              sent [NPORT];
  int              tot_sent;

  task automatic chk(input string name, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MSGW-1:0] mk(input int p, input int s);
    logic [MSGW-1:0] d;
    d          = '0;
    d[143:128] = 16'hA000 + 16'(p);
    d[39:32]   = 8'(p);
    d[31:0]    = 32'(s);
    return d;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int p = 0; p < NPORT; p++) m_hv[p] = 1'b0;
      m_fifo.delete();
      m_rr  = 0;
      m_cnt = '0;
    end else begin
      cyc++;
      if (pena && prdy) begin
        dlog.push_back(pv);
        dcyc.push_back(cyc);
      end
      for (int p = 0; p < NPORT; p++) m_acc[p] = ena[p] && !m_hv[p];
      m_pop = (m_fifo.size() != 0) && prdy;
      m_win = -1;
      for (int k = 0; k < NPORT; k++) begin
        if (m_win < 0 && m_hv[(m_rr + k) % NPORT]) m_win = (m_rr + k) % NPORT;
      end
      if (m_pop) begin
        void'(m_fifo.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (m_win >= 0 && (m_fifo.size() < 2)) begin
        m_fifo.push_back(m_hd[m_win]);
        m_hv[m_win] = 1'b0;
        m_rr = (m_win + 1) % NPORT;
      end
      for (int p = 0; p < NPORT; p++) begin
        if (m_acc[p]) begin
          m_hv[p] = 1'b1;
          m_hd[p] = vin[p*MSGW +: MSGW];
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int p = 0; p < NPORT; p++) m_erdy[p] = !m_hv[p];
    chk("model_rdy", MSGW'(rdy), MSGW'(m_erdy));
    chk("model_ena", MSGW'(pena), MSGW'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("model_data", pv, m_fifo[0]);
    chk("model_count", MSGW'(cnt), MSGW'(m_cnt));
  end

  task automatic do_reset();
    @(negedge CLK);
    #2 nRST = 1'b0;
    ena = '0;
    @(negedge CLK);
    #2 nRST = 1'b1;
    dlog.delete();
    dcyc.delete();
  endtask

  task automatic clr_sent();
    for (int p = 0; p < NPORT; p++) sent[p] = 0;
    tot_sent = 0;
  endtask

  // Offer messages on every free port until total is reached or cycles run out.
  task automatic stream(input int total, input int per_port, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge CLK);
      ena = '0;
      if (tot_sent >= total || c == max_cyc - 1) break;
      for (int p = 0; p < NPORT; p++) begin
        if (rdy[p] && tot_sent < total && sent[p] < per_port) begin
          ena[p] = 1'b1;
          vin[p*MSGW +: MSGW] = mk(p, sent[p]);
          sent[p]++;
          tot_sent++;
        end
      end
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    do begin
      @(negedge CLK);
      c++;
    end while ((pena || rdy != 4'hF) && c < max_cyc);
    chk("idle_timeout", MSGW'(pena || rdy != 4'hF), '0);
  endtask

  int nxt [NPORT];
  int pi;

  initial begin
    clr_sent();
    #1 nRST = 1'b0;
    #1;
    chk("reset_rdy", MSGW'(rdy), MSGW'(4'hF));
    chk("reset_ena", MSGW'(pena), '0);
    chk("reset_cnt", MSGW'(cnt), '0);
    @(negedge CLK);
    #2 nRST = 1'b1;

    // Single message on port 2
    prdy = 1'b1;
    @(negedge CLK);
    ena = 4'b0100;
    vin[2*MSGW +: MSGW] = 144'h0005_00000007;
    @(negedge CLK);
    ena = '0;
    chk("single_rdy", MSGW'(rdy), MSGW'(4'b1011));
    chk("single_ena_early", MSGW'(pena), '0);
    @(negedge CLK);
    chk("single_ena", MSGW'(pena), MSGW'(1'b1));
    chk("single_data", pv, 144'h0005_00000007);
    @(negedge CLK);
    chk("single_done", MSGW'(pena), '0);
    chk("single_cnt", MSGW'(cnt), MSGW'(16'd1));

    // Fairness from rr_ptr = 0
    do_reset();
    prdy = 1'b1;
    @(negedge CLK);
    ena = 4'hF;
    for (int p = 0; p < NPORT; p++) vin[p*MSGW +: MSGW] = mk(p, 100);
    @(negedge CLK);
    ena = '0;
    wait_idle(20);
    chk("fair_n", MSGW'(dlog.size()), MSGW'(4));
    if (dlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("fair_order", dlog[i], mk(i, 100));
      for (int i = 0; i < 3; i++) chk("fair_consec", MSGW'(dcyc[i+1] - dcyc[i]), MSGW'(1));
    end
    @(negedge CLK);
    ena = 4'b1010;
    vin[1*MSGW +: MSGW] = mk(1, 200);
    vin[3*MSGW +: MSGW] = mk(3, 200);
    @(negedge CLK);
    ena = '0;
    wait_idle(20);
    chk("fair_rr_n", MSGW'(dlog.size()), MSGW'(6));
    if (dlog.size() == 6) begin
      chk("fair_rr_first", dlog[4], mk(1, 200));
      chk("fair_rr_second", dlog[5], mk(3, 200));
    end

    // Backpressure: 2 FIFO + 4 hold slots, then drain
    do_reset();
    prdy = 1'b0;
    clr_sent();
    stream(8, 2, 10);
    chk("bp_accepted", MSGW'(tot_sent), MSGW'(6));
    chk("bp_rdy", MSGW'(rdy), '0);
    chk("bp_cnt_hold", MSGW'(cnt), '0);
    prdy = 1'b1;
    stream(8, 2, 40);
    wait_idle(20);
    chk("bp_n", MSGW'(dlog.size()), MSGW'(8));
    chk("bp_cnt", MSGW'(cnt), MSGW'(16'd8));
    for (int p = 0; p < NPORT; p++) nxt[p] = 0;
    foreach (dlog[i]) begin
      pi = int'(dlog[i][39:32]) % NPORT;
      chk("bp_order", MSGW'(dlog[i][31:0]), MSGW'(nxt[pi]));
      nxt[pi]++;
    end

    // Full FIFO: simultaneous pop and push
    do_reset();
    prdy = 1'b0;
    @(negedge CLK);
    ena = 4'b0101;
    vin[0*MSGW +: MSGW] = mk(0, 300);
    vin[2*MSGW +: MSGW] = mk(2, 300);
    @(negedge CLK);
    ena = '0;
    @(negedge CLK);
    @(negedge CLK);
    ena = 4'b0010;
    vin[1*MSGW +: MSGW] = mk(1, 300);
    @(negedge CLK);
    ena = '0;
    chk("pp_rdy_before", MSGW'(rdy), MSGW'(4'b1101));
    chk("pp_head_before", pv, mk(0, 300));
    prdy = 1'b1;
    @(negedge CLK);
    prdy = 1'b0;
    chk("pp_rdy_after", MSGW'(rdy), MSGW'(4'hF));
    chk("pp_ena_after", MSGW'(pena), MSGW'(1'b1));
    chk("pp_head_after", pv, mk(2, 300));
    chk("pp_cnt", MSGW'(cnt), MSGW'(16'd1));
    ena = 4'b1000;
    vin[3*MSGW +: MSGW] = mk(3, 300);
    @(negedge CLK);
    ena = '0;
    chk("pp_rdy_full", MSGW'(rdy), MSGW'(4'b0111));

    // Asynchronous reset with 3 messages queued
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ena", MSGW'(pena), '0);
    chk("mid_rst_rdy", MSGW'(rdy), MSGW'(4'hF));
    chk("mid_rst_cnt", MSGW'(cnt), '0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    dlog.delete();
    dcyc.delete();
    prdy = 1'b1;
    repeat (5) @(negedge CLK);
    chk("mid_rst_stale", MSGW'(dlog.size()), '0);
    ena = 4'b0001;
    vin[0*MSGW +: MSGW] = mk(0, 400);
    @(negedge CLK);
    ena = '0;
    wait_idle(20);
    chk("mid_rst_n", MSGW'(dlog.size()), MSGW'(1));
    if (dlog.size() >= 1) chk("mid_rst_first", dlog[0], mk(0, 400));
    chk("mid_rst_cnt2", MSGW'(cnt), MSGW'(16'd1));

    // Counter wrap
    do_reset();
    prdy = 1'b1;
    clr_sent();
    stream(65535, 65535, 70000);
    wait_idle(20);
    chk("wrap_pre", MSGW'(cnt), MSGW'(16'hFFFF));
    clr_sent();
    stream(1, 1, 5);
    wait_idle(20);
    chk("wrap_post", MSGW'(cnt), MSGW'(16'h0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m2p_pipe_arbiter.md
M2P_PIPE_ARBITER -- requirements
Module: m2p_pipe_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 4, meaning number of indication requesters sharing one pipe.
REQ-002 SHALL have parameter MSGW, default 144 (16+128), meaning width of one pipe message.
REQ-003 SHALL have ports: CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have ports: nRST  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: in$enq__ENA  input  NPORT  per-requester enqueue strobe.
REQ-006 SHALL have ports: in$enq$v  input  NPORT*MSGW  per-requester message; port i occupies bits [i*MSGW +: MSGW].
REQ-007 SHALL have ports: in$enq__RDY  output  NPORT  per-requester ready.
REQ-008 SHALL have ports: pipe$enq__ENA  output  1  message-valid strobe to the shared pipe.
REQ-009 SHALL have ports: pipe$enq$v  output  MSGW  message to the shared pipe.
REQ-010 SHALL have ports: pipe$enq__RDY  input  1  shared-pipe ready.
REQ-011 SHALL have ports: stat$count  output  16  total messages delivered to the pipe.

Function
REQ-012 SHALL hold one message per port in a hold slot (valid bit + MSGW data); in$enq__RDY[i] = !hold_valid[i], registered-only, never dependent on any ENA.
REQ-013 SHALL capture in$enq$v slice i into hold slot i and set hold_valid[i] on a cycle with in$enq__ENA[i] && in$enq__RDY[i]; ENA while not RDY is ignored.
REQ-014 SHALL contain a 2-entry output FIFO; pipe$enq__ENA = FIFO non-empty; pipe$enq$v = FIFO head, valid combinationally from registers.
REQ-015 SHALL pop the FIFO on pipe$enq__ENA && pipe$enq__RDY and increment stat$count by 1, wrapping 0xFFFF -> 0x0000.
REQ-016 SHALL arbitrate each cycle among set hold_valid bits, round-robin: priority starts at rr_ptr, ascends modulo NPORT.
REQ-017 SHALL move at most one winner per cycle into the FIFO, clearing its hold_valid, when FIFO count < 2, or count == 2 and a pop occurs that cycle.
REQ-018 SHALL set rr_ptr = (winner+1) mod NPORT after a move; rr_ptr unchanged when no move.
REQ-019 SHALL pass messages unmodified; per-port order preserved; no message dropped or duplicated.
REQ-020 SHALL give minimum latency 2 cycles: accept at edge t, FIFO write at edge t+1, pipe$enq__ENA high during cycle t+1, earliest pop at edge t+2.
REQ-021 SHALL not bypass freed slots: hold slot cleared at edge t re-asserts RDY in cycle t+1 only; per-port throughput max 1 per 2 cycles, aggregate max 1 per cycle.
REQ-022 SHALL, with pipe$enq__RDY held low, fill the FIFO (2) plus all hold slots (NPORT), then deassert all in$enq__RDY; no state changes until pipe$enq__RDY rises.
REQ-023 SHALL allow a simultaneous push and pop on the same edge at any FIFO count, with count unchanged.

Reset
REQ-024 SHALL, on nRST low (asynchronously, independent of CLK), clear hold_valid, FIFO count/pointers and stat$count, and set rr_ptr = 0.
REQ-025 SHALL drive these outputs during and immediately after reset: in$enq__RDY = all ones, pipe$enq__ENA = 0, stat$count = 0; data registers need no reset.
REQ-026 SHALL discard messages in flight when reset is asserted mid-operation; after release, the first accepted message is the first delivered.

Structure
REQ-027 SHALL place MSGW, the portal header field widths (16-bit length/method/tag fields) and the default NPORT in the shared out2int package.
REQ-028 SHALL implement the 2-entry output FIFO as one sub-module, m2p_fifo2 (enq/deq ENA/RDY, MSGW data, count output); arbitration and hold slots stay in the top module.

Verification
REQ-029 SHALL verify single message: reset, port 2 sends 0x0005_00000007 (low bits) with pipe RDY=1 -> pipe$enq__ENA high 1 cycle after accept, same value, stat$count=1.
REQ-030 SHALL verify fairness: all 4 ports enqueue A0..A3 in the same cycle, rr_ptr=0 -> pipe order A0,A1,A2,A3 on 4 consecutive cycles; rr_ptr=0 again.
REQ-031 SHALL verify backpressure: pipe RDY=0, ports 0..3 each send 2 messages -> 6 accepted, all in$enq__RDY=0; RDY=1 -> all 8 delivered, per-port order kept, stat$count=8.
REQ-032 SHALL verify full-FIFO push/pop: FIFO count 2, port 1 holding, pipe RDY=1 for one cycle -> pop and push on the same edge, count stays 2.
REQ-033 SHALL verify count wrap: preload via 65535 deliveries, send 1 more -> stat$count=0x0000.
REQ-034 SHALL verify reset mid-flow: nRST low with 3 messages queued -> pipe$enq__ENA=0 and in$enq__RDY=4'b1111 immediately, stat$count=0, no stale message after release.
